temp_sensor_ctrl: RTL and testbench
===================================

Name: temp_sensor_ctrl

Overview:
- Memory-mapped temperature-sensor controller. It is the bus slave at base 0x7004_0000 that the core's temp-wait tracker polls.
- A CPU write to CTRL starts a serial conversion read from an external SPI-mode-0 sensor ADC.
- STATUS bit0 reads 1 while the conversion runs. Software, and the upstream tracker, wait for bit0==0.
- The result is then readable in DATA.

Parameters:
- DATA_W, 16: bits shifted in per conversion (1..32).
- DIV_RST, 1: reset value of CLKDIV.
- ADDR_W, 32: bus address width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- req_i  in  1  bus access valid this cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_W  byte address; only addr_i[3:2] is decoded, base decode is done by the bus
- data_i  in  32  write data
- data_o  out  32  read data, combinational from addr_i when req_i=1 and we_i=0, else 0
- sens_cs_n_o  out  1  sensor chip select, active low
- sens_sclk_o  out  1  sensor serial clock, idle low
- sens_miso_i  in  1  sensor serial data

Behaviour:
- Register map:
  - 0x0 STATUS (RO, except W1C on bit1): bit0 busy, bit1 done (sticky), other bits 0.
  - 0x4 CTRL (WO pulse): bit0 start; reads as 0, or as IE when the optional feature is present.
  - 0x8 DATA (RO): last result, zero-extended to 32 bits.
  - 0xC CLKDIV (RW): bits[7:0], other bits read 0.
- Writes take effect at the clk edge where req_i=1 and we_i=1. Writes to RO registers are ignored.
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE; sens_cs_n_o=1, sens_sclk_o=0.
  - busy=0, done=0, DATA=0, CLKDIV=DIV_RST, shift register and counters 0.
  - A reset mid-conversion aborts it with no partial result.
- Half-period H = CLKDIV+1 cycles. CLKDIV is latched at start, so writes during busy affect only the next conversion. CLKDIV=0 gives H=1.
- FSM states:
  - IDLE: start accepted only if busy=0 at the write edge. On acceptance: go to CS_SETUP, busy=1 and done=0 next cycle, sens_cs_n_o=0. A start while busy is ignored with no error.
  - CS_SETUP: hold H cycles, then go to SHIFT.
  - SHIFT: for each of DATA_W bits, sclk low for H cycles then high for H cycles.
    - sens_miso_i is sampled on the cycle sclk rises, MSB first, into the shift register.
    - After the last high phase, sclk returns low and the FSM goes to CS_HOLD.
  - CS_HOLD: sens_cs_n_o=1, hold H cycles.
  - DONE (1 cycle): DATA is loaded from the shift register, busy goes 0 and done goes 1 from the next cycle; then return to IDLE.
- Latency: busy stays high for exactly (2*DATA_W+2)*H+1 cycles, counted from the first cycle after the start edge.
- DATA is only updated in DONE. Reads during busy return the previous result.
- Simultaneous events:
  - A start in the DONE cycle is ignored, because busy is still 1.
  - A W1C to done in the same cycle that DONE sets it: the set wins.
  - A start write with bit0=0 has no effect.

Optional Feature:
- Macro: TEMP_SENSOR_IRQ_EN.
- When defined:
  - Port irq_o (out, 1) is added.
  - CTRL bit1 becomes IE, a RW bit that resets to 0.
  - irq_o = done & IE, registered, reset 0.
  - CTRL reads return bit1=IE.
- When undefined:
  - No irq_o port.
  - CTRL bit1 is ignored on write and reads 0.

Decomposition:
- Package temp_sensor_pkg holds:
  - register offsets (STATUS/CTRL/DATA/CLKDIV)
  - STATUS bit indices
  - FSM state encoding (IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE)
  - the 0x7004_0000 base constant
- One sub-module, temp_spi_shifter. It owns the H counter, sclk generation, bit counter and shift register. Its interface is start in, H in, done pulse out, result out.
- The top module keeps the register file and the bus decode.

Test Plan:
1. Reset, then read all registers -> STATUS=0x0, DATA=0x0, CLKDIV=DIV_RST (0x1), sens_cs_n_o=1, sens_sclk_o=0.
2. CLKDIV=1, write CTRL=0x1, sensor model drives 0xA5C3 MSB-first -> busy for 69 cycles, 16 sclk rising edges each 4 cycles apart, then STATUS=0x2 and DATA=0x0000A5C3.
3. Write CTRL=0x1 twice 10 cycles apart -> one conversion only, 16 sclk edges, busy length unchanged.
4. Write CLKDIV=3 mid-conversion -> current sclk period stays 4 cycles; the next conversion uses an 8-cycle period; CLKDIV reads 0x3.
5. Assert rst during the SHIFT state at bit 7 -> cs_n_o=1 and sclk_o=0 immediately (asynchronous); STATUS=0 and DATA=0 after release.
6. With TEMP_SENSOR_IRQ_EN: CTRL=0x3, then conversion completes -> irq_o=1 the cycle after done. Write STATUS=0x2 -> done=0 and irq_o=0 the following cycle.

Source files
------------

// File: rtl/temp_sensor_pkg.sv
// Shared constants for the temperature-sensor controller: register offsets,
// STATUS/CTRL bit positions and the SPI sequencing state encoding.
package temp_sensor_pkg;

  localparam logic [31:0] TempSensorBase = 32'h7004_0000;

  // Word offsets, i.e. addr[3:2]
  localparam logic [1:0] RegStatus = 2'h0;
  localparam logic [1:0] RegCtrl   = 2'h1;
  localparam logic [1:0] RegData   = 2'h2;
  localparam logic [1:0] RegClkdiv = 2'h3;

  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;
  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlIeBit     = 1;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StDone
  } spi_state_e;

endpackage

// File: rtl/temp_spi_shifter.sv
// SPI mode-0 conversion sequencer: chip-select framing, sclk generation with a
// programmable half period, bit counting and MSB-first shift-in of the result.
module temp_spi_shifter
  import temp_sensor_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        half,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              cs_n,
  output logic              sclk,
  input  logic              miso
);

  localparam logic [5:0] BitLast = 6'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [8:0]        half_q, half_d;
  logic [5:0]        bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              last_cnt;

  assign last_cnt = (cnt_q == half_q - 9'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCsSetup;
          cnt_d   = '0;
          bit_d   = '0;
          half_d  = half;
          shreg_d = '0;
        end
      end
      StCsSetup: begin
        if (last_cnt) begin
          state_d = StShift;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StShift: begin
        if (last_cnt) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Sample on the edge that raises sclk; the sensor changes data on falling edges
            sclk_d  = 1'b1;
            shreg_d = (shreg_q << 1) | DATA_W'(miso);
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BitLast) begin
              state_d = StCsHold;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StCsHold: begin
        if (last_cnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      half_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      shreg_q <= shreg_d;
    end
  end

  assign done   = (state_q == StDone);
  assign result = shreg_q;
  assign cs_n   = !((state_q == StCsSetup) || (state_q == StShift));
  assign sclk   = sclk_q;

endmodule

// File: rtl/temp_sensor_ctrl.sv
// Memory-mapped temperature-sensor controller (STATUS/CTRL/DATA/CLKDIV).
// Define TEMP_SENSOR_IRQ_EN to add the CTRL.IE bit and the registered irq_o output.
module temp_sensor_ctrl
  import temp_sensor_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DIV_RST = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              sens_cs_n_o,
  output logic              sens_sclk_o,
  input  logic              sens_miso_i
`ifdef TEMP_SENSOR_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  logic              wr, rd;
  logic [1:0]        off;
  logic              start_acc;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        clkdiv_q, clkdiv_d;
  logic [8:0]        half;
  logic              shift_done;
  logic [DATA_W-1:0] shift_result;
  logic              ie;
  logic              unused_bits;

  assign wr  = req_i & we_i;
  assign rd  = req_i & ~we_i;
  assign off = addr_i[3:2];

  // A start while a conversion (including its DONE cycle) is in flight is dropped
  assign start_acc = wr && (off == RegCtrl) && data_i[CtrlStartBit] && !busy_q;
  assign half      = {1'b0, clkdiv_q} + 9'd1;

  assign unused_bits = ^{addr_i[ADDR_W-1:4], addr_i[1:0], data_i[31:8]};

  always_comb begin
    busy_d   = busy_q;
    done_d   = done_q;
    data_d   = data_q;
    clkdiv_d = clkdiv_q;
    if (start_acc) begin
      busy_d = 1'b1;
    end else if (shift_done) begin
      busy_d = 1'b0;
    end
    // Setting done outranks a simultaneous W1C
    if (shift_done) begin
      done_d = 1'b1;
      data_d = shift_result;
    end else if (start_acc) begin
      done_d = 1'b0;
    end else if (wr && (off == RegStatus) && data_i[StatusDoneBit]) begin
      done_d = 1'b0;
    end
    if (wr && (off == RegClkdiv)) begin
      clkdiv_d = data_i[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      clkdiv_q <= 8'(DIV_RST);
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      clkdiv_q <= clkdiv_d;
    end
  end

`ifdef TEMP_SENSOR_IRQ_EN
  logic ie_q;
  logic irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr && (off == RegCtrl)) begin
        ie_q <= data_i[CtrlIeBit];
      end
      irq_q <= done_q & ie_q;
    end
  end

  assign ie    = ie_q;
  assign irq_o = irq_q;
`else
  assign ie = 1'b0;
`endif

  always_comb begin
    data_o = '0;
    if (rd) begin
      unique case (off)
        RegStatus: begin
          data_o[StatusBusyBit] = busy_q;
          data_o[StatusDoneBit] = done_q;
        end
        RegCtrl:   data_o[CtrlIeBit] = ie;
        RegData:   data_o = 32'(data_q);
        RegClkdiv: data_o[7:0] = clkdiv_q;
        default:   data_o = '0;
      endcase
    end
  end

  temp_spi_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (start_acc),
    .half  (half),
    .done  (shift_done),
    .result(shift_result),
    .cs_n  (sens_cs_n_o),
    .sclk  (sens_sclk_o),
    .miso  (sens_miso_i)
  );

endmodule

// File: tb/tb_temp_sensor_ctrl.sv
// Randomised self-checking bench for temp_sensor_ctrl with a behavioural SPI sensor model.
// Build with TEMP_SENSOR_IRQ_EN defined to also exercise the interrupt path.
module tb_temp_sensor_ctrl;

  localparam logic [31:0] AStatus = 32'h7004_0000;
  localparam logic [31:0] ACtrl   = 32'h7004_0004;
  localparam logic [31:0] AData   = 32'h7004_0008;
  localparam logic [31:0] AClkdiv = 32'h7004_000C;
  localparam int NBits = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        cs_n, sclk;
  logic        miso = 1'b0;
`ifdef TEMP_SENSOR_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] sens_word = '0;
  int          bidx = 0;
  time         rises[$];

  always #5 clk = ~clk;

  temp_sensor_ctrl #(
    .DATA_W (16),
    .DIV_RST(1),
    .ADDR_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .data_i     (wdata),
    .data_o     (rdata),
    .sens_cs_n_o(cs_n),
    .sens_sclk_o(sclk),
    .sens_miso_i(miso)
`ifdef TEMP_SENSOR_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

  // Sensor: presents MSB when selected, shifts on each falling sclk edge
  always @(negedge cs_n) begin
    bidx = NBits - 1;
    miso = sens_word[bidx];
  end
  always @(negedge sclk) begin
    if (cs_n === 1'b0 && bidx > 0) begin
      bidx = bidx - 1;
      miso = sens_word[bidx];
    end
  end
  always @(posedge sclk) rises.push_back($time);

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    req = 1'b0;
  endtask

  // Starts a conversion and polls STATUS once per cycle until busy drops.
  task automatic do_conversion(input logic [31:0] ctrl_val, input logic [15:0] word,
                               input int restart_at, input int newdiv_at,
                               input logic [7:0] newdiv, input int exp_h,
                               output int busy_cycles, output logic [31:0] status,
                               output logic [31:0] data, output int bad_gaps);
    logic [31:0] st;
    bit finished;
    sens_word = word;
    rises.delete();
    busy_cycles = 0;
    finished = 0;
    st = '0;
    bus_write(ACtrl, ctrl_val);
    for (int i = 0; i < 20000; i++) begin
      if (i == restart_at) begin
        bus_write(ACtrl, 32'h1);
        busy_cycles++;
      end else if (i == newdiv_at) begin
        bus_write(AClkdiv, {24'h0, newdiv});
        busy_cycles++;
      end else begin
        bus_read(AStatus, st);
        if (st[0]) busy_cycles++;
        else begin
          finished = 1;
          break;
        end
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL conv_timeout: busy still 1 after %0d cycles, required 0", busy_cycles);
    end
    status = st;
    bad_gaps = 0;
    for (int k = 1; k < rises.size(); k++)
      if (rises[k] - rises[k-1] != time'(20 * exp_h)) bad_gaps++;
    bus_read(AData, data);
  endtask

  task automatic check_conv(input string name, input int h, input logic [15:0] word,
                            input int busy_cycles, input logic [31:0] status,
                            input logic [31:0] data, input int bad_gaps);
    int exp_busy;
    exp_busy = (2 * NBits + 2) * h + 1;
    checks++;
    if (busy_cycles !== exp_busy) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", name, busy_cycles, exp_busy);
    end
    checks++;
    if (rises.size() !== NBits) begin
      errors++;
      $display("FAIL %s sclk_edges: got %0d want %0d", name, rises.size(), NBits);
    end
    checks++;
    if (bad_gaps !== 0) begin
      errors++;
      $display("FAIL %s sclk_period: %0d gaps differ from %0d cycles", name, bad_gaps, 2 * h);
    end
    checks++;
    if (status !== 32'h2) begin
      errors++;
      $display("FAIL %s status: got %h want 00000002", name, status);
    end
    checks++;
    if (data !== {16'h0, word}) begin
      errors++;
      $display("FAIL %s data: got %h want %h", name, data, {16'h0, word});
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_read(AStatus, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", d); end
    bus_read(AData, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", d); end
    bus_read(AClkdiv, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_clkdiv: got %h want 1", d); end
    bus_read(ACtrl, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", d); end
    checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL rst_pins: cs_n=%b sclk=%b want 1/0", cs_n, sclk);
    end
  endtask

  task automatic test_basic();
    int bc, bg;
    logic [31:0] st, d;
    bus_write(AClkdiv, 32'h1);
    do_conversion(32'h1, 16'hA5C3, -1, -1, 8'h0, 2, bc, st, d, bg);
    check_conv("basic", 2, 16'hA5C3, bc, st, d, bg);
  endtask

  task automatic test_double_start();
    int bc, bg;
    logic [31:0] st, d;
    logic [15:0] w;
    w = 16'($urandom);
    do_conversion(32'h1, w, 9, -1, 8'h0, 2, bc, st, d, bg);
    check_conv("double_start", 2, w, bc, st, d, bg);
  endtask

  task automatic test_clkdiv_change();
    int bc, bg;
    logic [31:0] st, d;
    logic [15:0] w;
    w = 16'($urandom);
    do_conversion(32'h1, w, -1, 20, 8'h3, 2, bc, st, d, bg);
    check_conv("div_mid", 2, w, bc, st, d, bg);
    bus_read(AClkdiv, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL div_readback: got %h want 3", d); end
    w = 16'($urandom);
    do_conversion(32'h1, w, -1, -1, 8'h0, 4, bc, st, d, bg);
    check_conv("div_next", 4, w, bc, st, d, bg);
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(AStatus, 32'h2);
    bus_read(AStatus, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_done: got %h want 0", d); end
    bus_read(AData, d);
    bus_write(AData, 32'hFFFF_FFFF);
    begin
      logic [31:0] d2;
      bus_read(AData, d2);
      checks++; if (d2 !== d) begin errors++; $display("FAIL data_ro: got %h want %h", d2, d); end
    end
    bus_write(AClkdiv, 32'hFFFF_FF05);
    bus_read(AClkdiv, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL div_width: got %h want 5", d); end
    bus_write(ACtrl, 32'h0);
    begin
      int busy_seen = 0;
      for (int i = 0; i < 5; i++) begin
        bus_read(AStatus, d);
        if (d[0] || cs_n !== 1'b1) busy_seen++;
      end
      checks++;
      if (busy_seen !== 0) begin
        errors++;
        $display("FAIL start_zero: busy/cs active in %0d cycles, want 0", busy_seen);
      end
    end
  endtask

  task automatic test_random();
    int bc, bg, h;
    logic [31:0] st, d;
    logic [15:0] w;
    for (int n = 0; n < 3; n++) begin
      h = int'($urandom_range(0, 2)) + 1;
      if (n == 0) h = 1;
      w = 16'($urandom);
      bus_write(AClkdiv, 32'(h - 1));
      do_conversion(32'h1, w, -1, -1, 8'h0, h, bc, st, d, bg);
      check_conv("random", h, w, bc, st, d, bg);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    bit reached = 0;
    bus_write(AClkdiv, 32'h3);
    sens_word = 16'($urandom);
    rises.delete();
    bus_write(ACtrl, 32'h1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rises.size() >= 8) begin
        reached = 1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL abort_reach: saw %0d sclk edges, want 8", rises.size());
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL abort_pins: cs_n=%b sclk=%b want 1/0", cs_n, sclk);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_read(AStatus, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_status: got %h want 0", d); end
    bus_read(AData, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_data: got %h want 0", d); end
    bus_read(AClkdiv, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL abort_div: got %h want 1", d); end
  endtask

`ifdef TEMP_SENSOR_IRQ_EN
  task automatic test_irq();
    int bc, bg;
    logic [31:0] st, d;
    logic [15:0] w;
    w = 16'($urandom);
    bus_write(AClkdiv, 32'h0);
    do_conversion(32'h3, w, -1, -1, 8'h0, 1, bc, st, d, bg);
    check_conv("irq_conv", 1, w, bc, st, d, bg);
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
    bus_read(ACtrl, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL irq_ie_read: got %h want 2", d); end
    bus_write(AStatus, 32'h2);
    bus_read(AStatus, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_w1c: got %h want 0", d); end
    @(negedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq); end
    bus_write(ACtrl, 32'h0);
  endtask
`endif

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_basic();
    test_double_start();
    test_clkdiv_change();
    test_regs();
    test_random();
    test_reset_abort();
`ifdef TEMP_SENSOR_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
